axi_single_master: RTL and testbench

- Single-outstanding AXI4 memory master between the CPU memory-request interface and the AXI interconnect.
- Accepts one 32-bit read or write request at a time and issues it as a single-beat INCR burst: length 1, 4-byte size.
- Returns read data and a response status to the requester.
- Static AXI sideband fields (IDs, LEN, SIZE, BURST, CACHE, PROT, QOS, USER, WSTRB, BREADY=1) come from the existing AXI constant block and are not driven here.
- BREADY is permanently high, so this block must accept B whenever it arrives.

---
 rtl/axi_single_master_if.sv | 52 +++++
 rtl/axi_single_master.sv | 165 ++++++++++++++++
 tb/tb_axi_single_master.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_single_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_single_master_if
// Description : Request/response and AXI4 channel bundle for axi_single_master.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_single_master_if #(
  parameter int C_AXI_ADDR_WIDTH = 32
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [C_AXI_ADDR_WIDTH-1:0] req_addr;
  logic [31:0]                 req_wdata;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [31:0]                 resp_rdata;
  logic                        resp_err;

  logic [C_AXI_ADDR_WIDTH-1:0] AWADDR;
  logic                        AWVALID;
  logic                        AWREADY;
  logic [31:0]                 WDATA;
  logic                        WLAST;
  logic                        WVALID;
  logic                        WREADY;
  logic [1:0]                  BRESP;
  logic                        BVALID;
  logic [C_AXI_ADDR_WIDTH-1:0] ARADDR;
  logic                        ARVALID;
  logic                        ARREADY;
  logic [31:0]                 RDATA;
  logic [1:0]                  RRESP;
  logic                        RLAST;
  logic                        RVALID;
  logic                        RREADY;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
           AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID,
    output req_ready, resp_valid, resp_rdata, resp_err,
           AWADDR, AWVALID, WDATA, WLAST, WVALID, ARADDR, ARVALID, RREADY
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
           AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           AWADDR, AWVALID, WDATA, WLAST, WVALID, ARADDR, ARVALID, RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axi_single_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_single_master
// Description : Single-outstanding AXI4 master issuing one-beat reads/writes.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_single_master #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  axi_single_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WR_ADDR_DATA = 3'd1,
    S_WR_RESP      = 3'd2,
    S_RD_ADDR      = 3'd3,
    S_RD_DATA      = 3'd4,
    S_RESP         = 3'd5
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic                        r_awvalid;
  logic                        r_wvalid;
  logic                        r_arvalid;
  logic                        r_rready;
  logic                        r_resp_valid;
  logic                        r_resp_err;
  logic [C_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [C_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [C_AXI_DATA_WIDTH-1:0] r_rdata;
  logic                        w_aw_done;
  logic                        w_w_done;
  logic                        w_unused;

  // A channel counts as done once its valid has dropped or it handshakes now.
  assign w_aw_done = !r_awvalid || bus.AWREADY;
  assign w_w_done  = !r_wvalid  || bus.WREADY;
  assign w_unused  = ^bus.req_addr[1:0];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state_next = bus.req_we ? S_WR_ADDR_DATA : S_RD_ADDR;
        end
      end
      S_WR_ADDR_DATA: begin
        if (w_aw_done && w_w_done) begin
          w_state_next = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (bus.BVALID) begin
          w_state_next = S_RESP;
        end
      end
      S_RD_ADDR: begin
        if (bus.ARREADY) begin
          w_state_next = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bus.RVALID) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr    <= {bus.req_addr[C_AXI_ADDR_WIDTH-1:2], 2'b00};
            r_wdata   <= bus.req_wdata;
            r_awvalid <= bus.req_we;
            r_wvalid  <= bus.req_we;
            r_arvalid <= !bus.req_we;
          end
        end
        S_WR_ADDR_DATA: begin
          if (r_awvalid && bus.AWREADY) begin
            r_awvalid <= 1'b0;
          end
          if (r_wvalid && bus.WREADY) begin
            r_wvalid <= 1'b0;
          end
        end
        S_WR_RESP: begin
          if (bus.BVALID) begin
            r_resp_err   <= (bus.BRESP != 2'b00);
            r_rdata      <= '0;
            r_resp_valid <= 1'b1;
          end
        end
        S_RD_ADDR: begin
          if (bus.ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        S_RD_DATA: begin
          if (bus.RVALID) begin
            r_rready     <= 1'b0;
            r_rdata      <= bus.RDATA;
            r_resp_err   <= (bus.RRESP != 2'b00) || !bus.RLAST;
            r_resp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.AWADDR     = r_addr;
  assign bus.AWVALID    = r_awvalid;
  assign bus.WDATA      = r_wdata;
  assign bus.WLAST      = r_wvalid;
  assign bus.WVALID     = r_wvalid;
  assign bus.ARADDR     = r_addr;
  assign bus.ARVALID    = r_arvalid;
  assign bus.RREADY     = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_single_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_single_master
// Description : Randomised AXI slave + transaction-level model for axi_single_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_single_master;

  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_B, P_R, P_RESP} phase_e;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  axi_single_master_if #(.C_AXI_ADDR_WIDTH(32)) bus ();

  axi_single_master #(
    .C_AXI_ADDR_WIDTH(32),
    .C_AXI_DATA_WIDTH(32)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // slave behaviour knobs
  logic        rnd_mode = 1'b0;
  int          aw_delay = 0;
  int          w_delay = 0;
  int          ar_delay = 0;
  int          r_delay = 0;
  int          b_delay = 0;
  logic [1:0]  bresp_v = 2'b00;
  logic [1:0]  rresp_v = 2'b00;
  logic        rlast_v = 1'b1;
  logic        rr_rand = 1'b0;
  logic        rr_force = 1'b1;

  logic [31:0] smem [logic [31:0]];
  logic [31:0] mref [logic [31:0]];

  // observations shared with the directed sequences
  int          done_cnt = 0;
  int          accept_cyc = 0;
  int          respv_cyc = 0;
  int          aw_hi = 0;
  int          w_hi = 0;
  int          b_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic [31:0] last_araddr = '0;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // AXI slave: random or directed stalls, memory backed by smem
  initial begin : slave
    logic hs_aw, hs_w, hs_ar, hs_r, hs_b;
    logic [31:0] c_awaddr, c_wdata, c_araddr;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic aw_got, w_got, b_pend, r_pend;
    int b_wait, r_wait, aw_seen, w_seen, ar_seen;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    b_wait = 0; r_wait = 0; aw_seen = 0; w_seen = 0; ar_seen = 0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0;
    bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
    bus.BVALID = 0; bus.BRESP = 0;
    bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0; bus.RLAST = 0;
    forever begin
      @(negedge ACLK);
      hs_aw = bus.AWVALID && bus.AWREADY;
      hs_w  = bus.WVALID && bus.WREADY;
      hs_ar = bus.ARVALID && bus.ARREADY;
      hs_r  = bus.RVALID && bus.RREADY;
      hs_b  = bus.BVALID;
      c_awaddr = bus.AWADDR; c_wdata = bus.WDATA; c_araddr = bus.ARADDR;
      @(posedge ACLK); #1;
      if (!ARESETN) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
        bus.BVALID = 0; bus.RVALID = 0;
      end else begin
        if (hs_b) bus.BVALID = 0;
        if (hs_r) bus.RVALID = 0;
        if (hs_aw) begin s_awaddr = c_awaddr; aw_got = 1; end
        if (hs_w) begin s_wdata = c_wdata; w_got = 1; end
        if (aw_got && w_got) begin
          smem[s_awaddr] = s_wdata;
          aw_got = 0; w_got = 0; b_pend = 1;
          b_wait = rnd_mode ? int'($urandom_range(0, 3)) : b_delay;
        end
        if (b_pend) begin
          if (b_wait == 0) begin
            bus.BVALID = 1;
            bus.BRESP = rnd_mode ? 2'($urandom_range(0, 3) == 0 ? 2 : 0) : bresp_v;
            b_pend = 0;
          end else b_wait--;
        end
        if (hs_ar) begin
          s_araddr = c_araddr; r_pend = 1;
          r_wait = rnd_mode ? int'($urandom_range(0, 3)) : r_delay;
        end
        if (r_pend) begin
          if (r_wait == 0) begin
            bus.RVALID = 1;
            bus.RDATA = smem.exists(s_araddr) ? smem[s_araddr] : fill(s_araddr);
            bus.RRESP = rnd_mode ? 2'($urandom_range(0, 5) == 0 ? 3 : 0) : rresp_v;
            bus.RLAST = rnd_mode ? ($urandom_range(0, 5) != 0) : rlast_v;
            r_pend = 0;
          end else r_wait--;
        end
        if (bus.AWVALID) begin
          bus.AWREADY = rnd_mode ? ($urandom_range(0, 2) != 0) : (aw_seen >= aw_delay);
          aw_seen++;
        end else begin bus.AWREADY = 0; aw_seen = 0; end
        if (bus.WVALID) begin
          bus.WREADY = rnd_mode ? ($urandom_range(0, 2) != 0) : (w_seen >= w_delay);
          w_seen++;
        end else begin bus.WREADY = 0; w_seen = 0; end
        if (bus.ARVALID) begin
          bus.ARREADY = rnd_mode ? ($urandom_range(0, 2) != 0) : (ar_seen >= ar_delay);
          ar_seen++;
        end else begin bus.ARREADY = 0; ar_seen = 0; end
      end
    end
  end

  initial begin : resp_drv
    bus.resp_ready = 0;
    forever begin
      @(posedge ACLK); #1;
      bus.resp_ready = rr_rand ? ($urandom_range(0, 1) != 0) : rr_force;
    end
  end

  // Transaction-level model: one request in flight, walked through its phases
  initial begin : scoreboard
    phase_e ph;
    logic cur_we, aw_done, w_done, exp_err, prev_rv;
    logic e_aw, e_w, e_ar, e_rr, e_rv, e_rq;
    logic [31:0] cur_addr, cur_wdata, exp_data;
    ph = P_IDLE; cur_we = 0; aw_done = 0; w_done = 0; exp_err = 0; prev_rv = 0;
    cur_addr = 0; cur_wdata = 0; exp_data = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        ph = P_IDLE; prev_rv = 0;
      end else begin
        e_aw = (ph == P_ADDR) && cur_we && !aw_done;
        e_w  = (ph == P_ADDR) && cur_we && !w_done;
        e_ar = (ph == P_ADDR) && !cur_we;
        e_rr = (ph == P_R);
        e_rv = (ph == P_RESP);
        e_rq = (ph == P_IDLE);
        chk("ctrl{aw,w,ar,rready,resp_valid,req_ready}",
            {26'd0, bus.AWVALID, bus.WVALID, bus.ARVALID, bus.RREADY, bus.resp_valid, bus.req_ready},
            {26'd0, e_aw, e_w, e_ar, e_rr, e_rv, e_rq});
        if (e_aw) chk("AWADDR", bus.AWADDR, cur_addr);
        if (e_w) begin
          chk("WDATA", bus.WDATA, cur_wdata);
          chk("WLAST", {31'd0, bus.WLAST}, 32'd1);
        end
        if (e_ar) begin
          chk("ARADDR", bus.ARADDR, cur_addr);
          last_araddr = bus.ARADDR;
        end
        if (e_rv) begin
          chk("resp_rdata", bus.resp_rdata, exp_data);
          chk("resp_err", {31'd0, bus.resp_err}, {31'd0, exp_err});
        end
        if (bus.AWVALID) aw_hi++;
        if (bus.WVALID) w_hi++;
        if (bus.BVALID) b_cnt++;
        if (bus.resp_valid && !prev_rv) respv_cyc = cyc;
        prev_rv = bus.resp_valid;
        case (ph)
          P_IDLE: if (bus.req_valid) begin
            cur_we = bus.req_we;
            cur_addr = bus.req_addr & ~32'd3;
            cur_wdata = bus.req_wdata;
            aw_done = 0; w_done = 0;
            accept_cyc = cyc; aw_hi = 0; w_hi = 0;
            ph = P_ADDR;
          end
          P_ADDR: if (cur_we) begin
            if (e_aw && bus.AWREADY) aw_done = 1;
            if (e_w && bus.WREADY) w_done = 1;
            if (aw_done && w_done) ph = P_B;
          end else if (bus.ARREADY) ph = P_R;
          P_B: if (bus.BVALID) begin
            exp_data = 0;
            exp_err = (bus.BRESP != 2'b00);
            mref[cur_addr] = cur_wdata;
            ph = P_RESP;
          end
          P_R: if (bus.RVALID) begin
            exp_data = mref.exists(cur_addr) ? mref[cur_addr] : fill(cur_addr);
            exp_err = (bus.RRESP != 2'b00) || !bus.RLAST;
            ph = P_RESP;
          end
          P_RESP: if (bus.resp_ready) begin
            last_rdata = bus.resp_rdata;
            last_err = bus.resp_err;
            done_cnt++;
            ph = P_IDLE;
          end
          default: ph = P_IDLE;
        endcase
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
    int t;
    @(posedge ACLK); #1;
    bus.req_valid = 1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    t = 0;
    do begin @(negedge ACLK); t++; end while (!bus.req_ready && t < 200);
    if (!bus.req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
    end
    @(posedge ACLK); #1;
    bus.req_valid = 0;
  endtask

  task automatic wait_done(input int n0);
    int t;
    t = 0;
    while (done_cnt == n0 && t < 300) begin @(negedge ACLK); t++; end
    if (done_cnt == n0) begin
      checks++; failures++;
      $display("FAIL resp_timeout: got no response expected one within 300 cycles");
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    int n0;
    n0 = done_cnt;
    issue(we, a, d);
    wait_done(n0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n0, b0, rdy_seen, stall_rv, t;
    logic pre_aw;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_valids", {27'd0, bus.AWVALID, bus.WVALID, bus.ARVALID, bus.RREADY, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_addr_data", bus.AWADDR | bus.ARADDR | bus.WDATA, 32'd0);
    @(negedge ACLK); ARESETN = 1;

    // zero-wait read: accept, AR, R, RESP spans four cycles
    smem[32'h1000_0004] = 32'hDEAD_BEEF;
    mref[32'h1000_0004] = 32'hDEAD_BEEF;
    do_req(1'b0, 32'h1000_0006, 32'h0);
    chk("rd_araddr", last_araddr, 32'h1000_0004);
    chk("rd_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("rd_err", {31'd0, last_err}, 32'd0);
    chk("rd_latency", respv_cyc - accept_cyc, 32'd3);

    // write with AWREADY held off, WREADY immediate
    aw_delay = 2;
    b0 = b_cnt;
    do_req(1'b1, 32'h0000_0020, 32'h1234_5678);
    aw_delay = 0;
    chk("wr_awvalid_cycles", aw_hi, 32'd3);
    chk("wr_wvalid_cycles", w_hi, 32'd1);
    chk("wr_b_count", b_cnt - b0, 32'd1);
    chk("wr_err", {31'd0, last_err}, 32'd0);
    chk("wr_rdata", last_rdata, 32'd0);

    // error responses
    bresp_v = 2'b10;
    do_req(1'b1, 32'h0000_0024, 32'hCAFE_F00D);
    bresp_v = 2'b00;
    chk("bresp_err", {31'd0, last_err}, 32'd1);
    rlast_v = 1'b0;
    do_req(1'b0, 32'h0000_0021, 32'h0);
    rlast_v = 1'b1;
    chk("rlast_err", {31'd0, last_err}, 32'd1);
    chk("rlast_rdata", last_rdata, 32'h1234_5678);

    // response backpressure with a competing request held on req_valid
    rr_force = 0;
    n0 = done_cnt;
    issue(1'b0, 32'h0000_0024, 32'h0);
    t = 0;
    while (!bus.resp_valid && t < 50) begin @(negedge ACLK); t++; end
    rdy_seen = 0; stall_rv = 0;
    repeat (5) begin
      @(posedge ACLK); #1;
      bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h80; bus.req_wdata = 32'h5555_AAAA;
      @(negedge ACLK);
      if (bus.req_ready) rdy_seen++;
      if (bus.resp_valid) stall_rv++;
    end
    @(posedge ACLK); #1;
    bus.req_valid = 0;
    rr_force = 1;
    wait_done(n0);
    chk("bp_req_ready_cycles", rdy_seen, 32'd0);
    chk("bp_resp_valid_cycles", stall_rv, 32'd5);
    chk("bp_rdata", last_rdata, 32'hCAFE_F00D);

    // asynchronous reset while AWVALID is pending
    aw_delay = 20;
    issue(1'b1, 32'h0000_0800, 32'h0BAD_0BAD);
    @(negedge ACLK);
    pre_aw = bus.AWVALID;
    #2 ARESETN = 0;
    #1;
    chk("pre_reset_awvalid", {31'd0, pre_aw}, 32'd1);
    chk("async_rst_valids", {29'd0, bus.AWVALID, bus.WVALID, bus.resp_valid}, 32'd0);
    repeat (2) @(posedge ACLK);
    aw_delay = 0;
    @(negedge ACLK); #1 ARESETN = 1;
    @(negedge ACLK);
    chk("post_reset_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // alternating stream under random slave stalls and response backpressure
    rnd_mode = 1; rr_rand = 1;
    n0 = done_cnt;
    for (int i = 0; i < 24; i++) begin
      do_req((i % 2) == 1, 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3), $urandom);
    end
    rnd_mode = 0; rr_rand = 0;
    chk("stream_count", done_cnt - n0, 32'd24);

    repeat (3) @(posedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
